// File: rtl/mel_frame_seq.sv
// mel_frame_seq: runs one log-mel frame at a time through bin accumulation, log LUT issue,
// delayed buffer writes and a ready/valid output stream, with decimation, resync and overrun counts.
module mel_frame_seq #(
  parameter int FFT_BINS = 128,
  parameter int MEL_BINS = 40,
  parameter int LOG_LAT = 2,
  parameter int DECIM = 1,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fft_valid_i,
  input  logic                        fft_sync_i,
  input  logic                        fb_done_i,
  output logic                        fb_clear_o,
  output logic                        log_en_o,
  output logic [$clog2(MEL_BINS)-1:0] log_idx_o,
  output logic                        buf_wr_en_o,
  output logic [$clog2(MEL_BINS)-1:0] buf_wr_idx_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [$clog2(MEL_BINS)-1:0] out_idx_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        sync_err_o,
  output logic                        drop_o,
  output logic [CNT_W-1:0]            drop_cnt_o,
  output logic [CNT_W-1:0]            frame_cnt_o
);
  localparam int IW = $clog2(MEL_BINS);
  localparam int BW = $clog2(FFT_BINS);
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int LW = LOG_LAT > 1 ? $clog2(LOG_LAT) : 1;
  typedef enum logic [2:0] {IDLE, ACCUM, WAIT_FB, LOG, DRAIN, OUTPUT} state_t;
  state_t state, state_nx;
  logic [BW-1:0] bin_cnt;
  logic [IW-1:0] mel_cnt, out_cnt;
  logic [DW-1:0] dec_cnt;
  logic [LW-1:0] dr_cnt;
  logic sync, hs, mel_last, dr_last;
  assign sync = fft_valid_i & fft_sync_i;
  assign hs = out_valid_o & out_ready_i;
  assign mel_last = mel_cnt == IW'(MEL_BINS - 1);
  assign dr_last = dr_cnt == LW'(LOG_LAT - 1);
  assign log_en_o = state == LOG;
  assign log_idx_o = mel_cnt;
  assign out_valid_o = state == OUTPUT;
  assign out_idx_o = out_cnt;
  assign out_last_o = out_valid_o & (out_cnt == IW'(MEL_BINS - 1));
  assign busy_o = state != IDLE;
  always_comb begin
    state_nx = state;
    fb_clear_o = 1'b0;
    sync_err_o = 1'b0;
    drop_o = 1'b0;
    case (state)
      IDLE: if (sync && dec_cnt == '0) begin
        fb_clear_o = !reset;
        state_nx = ACCUM;
      end
      ACCUM: if (sync) begin
        fb_clear_o = 1'b1;
        sync_err_o = 1'b1;
      end else if (fft_valid_i && bin_cnt == BW'(FFT_BINS - 1)) state_nx = WAIT_FB;
      WAIT_FB: begin
        drop_o = sync;
        if (fb_done_i) state_nx = LOG;
      end
      LOG: begin
        drop_o = sync;
        if (mel_last) state_nx = LOG_LAT == 0 ? OUTPUT : DRAIN;
      end
      DRAIN: begin
        drop_o = sync;
        if (dr_last) state_nx = OUTPUT;
      end
      OUTPUT: begin
        drop_o = sync;
        if (hs && out_last_o) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bin_cnt <= '0;
      mel_cnt <= '0;
      out_cnt <= '0;
      dec_cnt <= '0;
      dr_cnt <= '0;
      drop_cnt_o <= '0;
      frame_cnt_o <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && sync) dec_cnt <= dec_cnt == DW'(DECIM - 1) ? '0 : dec_cnt + 1'b1;
      bin_cnt <= fb_clear_o ? BW'(1) : (state == ACCUM && fft_valid_i) ? bin_cnt + 1'b1 : bin_cnt;
      mel_cnt <= (state == LOG && !mel_last) ? mel_cnt + 1'b1 : '0;
      dr_cnt <= (state == DRAIN && !dr_last) ? dr_cnt + 1'b1 : '0;
      out_cnt <= !out_valid_o ? '0 : hs ? (out_last_o ? '0 : out_cnt + 1'b1) : out_cnt;
      if (hs && out_last_o) frame_cnt_o <= frame_cnt_o + 1'b1;
      if (drop_o && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
  // write strobes trail the LUT issue by its latency so data and address arrive together
  generate
    if (LOG_LAT == 0) begin : g_wire
      assign buf_wr_en_o = log_en_o;
      assign buf_wr_idx_o = log_idx_o;
    end else begin : g_pipe
      logic [LOG_LAT-1:0] en_d;
      logic [LOG_LAT-1:0][IW-1:0] idx_d;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          en_d <= '0;
          idx_d <= '0;
        end else begin
          en_d[0] <= log_en_o;
          idx_d[0] <= log_idx_o;
          for (int i = 1; i < LOG_LAT; i++) begin
            en_d[i] <= en_d[i-1];
            idx_d[i] <= idx_d[i-1];
          end
        end
      end
      assign buf_wr_en_o = en_d[LOG_LAT-1];
      assign buf_wr_idx_o = idx_d[LOG_LAT-1];
    end
  endgenerate
endmodule

// File: tb/tb_mel_frame_seq.sv
// tb_mel_frame_seq: two sequencer instances (defaults; LOG_LAT=0/DECIM=3/CNT_W=2) checked every
// cycle against a timestamp-based frame model.
module tb_mel_frame_seq;
  localparam int FB = 128;
  localparam int M = 40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic fft_valid = 1'b0, fft_sync = 1'b0, fb_done = 1'b0, out_ready = 1'b0;
  logic a_fb_clear, a_log_en, a_wr_en, a_out_valid, a_out_last, a_busy, a_sync_err, a_drop;
  logic b_fb_clear, b_log_en, b_wr_en, b_out_valid, b_out_last, b_busy, b_sync_err, b_drop;
  logic [5:0] a_log_idx, a_wr_idx, a_out_idx, b_log_idx, b_wr_idx, b_out_idx;
  logic [15:0] a_drop_cnt, a_frame_cnt;
  logic [1:0] b_drop_cnt, b_frame_cnt;
  logic o_fb_clear, o_log_en, o_wr_en, o_out_valid, o_out_last, o_busy, o_sync_err, o_drop;
  logic [5:0] o_log_idx, o_wr_idx, o_out_idx;
  logic [15:0] o_drop_cnt, o_frame_cnt;
  int checks = 0, errors = 0;
  int cyc = 0, nb, t_log, hs, dec, frames, drops, lat, dm, mask;
  bit in_frame, idle, sb, in_acc, in_wait, acc_new, e_log, e_wr, e_ov, e_drop;

  always #5 clk = ~clk;

  mel_frame_seq u_a (
    .clk(clk), .reset(reset), .fft_valid_i(fft_valid & !sel), .fft_sync_i(fft_sync),
    .fb_done_i(fb_done & !sel), .fb_clear_o(a_fb_clear), .log_en_o(a_log_en), .log_idx_o(a_log_idx),
    .buf_wr_en_o(a_wr_en), .buf_wr_idx_o(a_wr_idx), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_idx_o(a_out_idx), .out_last_o(a_out_last), .busy_o(a_busy), .sync_err_o(a_sync_err),
    .drop_o(a_drop), .drop_cnt_o(a_drop_cnt), .frame_cnt_o(a_frame_cnt));

  mel_frame_seq #(.LOG_LAT(0), .DECIM(3), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .fft_valid_i(fft_valid & sel), .fft_sync_i(fft_sync),
    .fb_done_i(fb_done & sel), .fb_clear_o(b_fb_clear), .log_en_o(b_log_en), .log_idx_o(b_log_idx),
    .buf_wr_en_o(b_wr_en), .buf_wr_idx_o(b_wr_idx), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_idx_o(b_out_idx), .out_last_o(b_out_last), .busy_o(b_busy), .sync_err_o(b_sync_err),
    .drop_o(b_drop), .drop_cnt_o(b_drop_cnt), .frame_cnt_o(b_frame_cnt));

  assign o_fb_clear = sel ? b_fb_clear : a_fb_clear;
  assign o_log_en = sel ? b_log_en : a_log_en;
  assign o_log_idx = sel ? b_log_idx : a_log_idx;
  assign o_wr_en = sel ? b_wr_en : a_wr_en;
  assign o_wr_idx = sel ? b_wr_idx : a_wr_idx;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_idx = sel ? b_out_idx : a_out_idx;
  assign o_out_last = sel ? b_out_last : a_out_last;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_sync_err = sel ? b_sync_err : a_sync_err;
  assign o_drop = sel ? b_drop : a_drop;
  assign o_drop_cnt = sel ? {14'b0, b_drop_cnt} : a_drop_cnt;
  assign o_frame_cnt = sel ? {14'b0, b_frame_cnt} : a_frame_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d got %0d exp %0d", tag, cyc, got, exp);
    end
  endtask

  // The model tracks a frame as beat counts and timestamps: LOG starts the cycle after fb_done,
  // writes trail by lat, the stream opens after LOG+lat and closes after M handshakes.
  task automatic check();
    sb = fft_valid && fft_sync;
    idle = !in_frame;
    in_acc = in_frame && nb < FB;
    in_wait = in_frame && nb >= FB && t_log < 0;
    acc_new = sb && idle && dec == 0;
    e_drop = sb && in_frame && !in_acc;
    e_log = t_log >= 0 && cyc >= t_log && cyc < t_log + M;
    e_wr = t_log >= 0 && cyc >= t_log + lat && cyc < t_log + M + lat;
    e_ov = in_frame && t_log >= 0 && cyc >= t_log + M + lat;
    chk("fb_clear", o_fb_clear, acc_new || (sb && in_acc));
    chk("sync_err", o_sync_err, sb && in_acc);
    chk("drop", o_drop, e_drop);
    chk("log_en", o_log_en, e_log);
    chk("log_idx", o_log_idx, e_log ? cyc - t_log : 0);
    chk("wr_en", o_wr_en, e_wr);
    chk("wr_idx", o_wr_idx, e_wr ? cyc - t_log - lat : 0);
    chk("out_valid", o_out_valid, e_ov);
    chk("out_idx", o_out_idx, e_ov ? hs : 0);
    chk("out_last", o_out_last, e_ov && hs == M - 1);
    chk("busy", o_busy, in_frame);
    chk("frame_cnt", o_frame_cnt, frames & mask);
    chk("drop_cnt", o_drop_cnt, drops);
  endtask

  task automatic step(input logic v, input logic s, input logic d, input logic r);
    fft_valid = v;
    fft_sync = s;
    fb_done = d;
    out_ready = r;
    #1 check();
    @(posedge clk);
    #1;
    if (e_ov && out_ready) hs++;
    if (in_acc && fft_valid) nb = sb ? 1 : nb + 1;
    if (in_wait && fb_done) t_log = cyc + 1;
    if (hs == M) begin
      in_frame = 0;
      t_log = -1;
      hs = 0;
      frames++;
    end
    if (sb && idle) dec = (dec + 1) % dm;
    if (acc_new) begin
      in_frame = 1;
      nb = 1;
    end
    if (e_drop && drops < mask) drops++;
    cyc++;
  endtask

  task automatic do_reset(input logic s);
    fft_valid = 0;
    fft_sync = 0;
    fb_done = 0;
    #2 reset = 1;
    sel = s;
    lat = s ? 0 : 2;
    dm = s ? 3 : 1;
    mask = s ? 3 : 16'hFFFF;
    in_frame = 0;
    t_log = -1;
    hs = 0;
    nb = 0;
    dec = 0;
    frames = 0;
    drops = 0;
    #1 check();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  function automatic logic rdy(input int m);
    return m == 0 ? 1'b1 : m == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 1) == 1);
  endfunction

  task automatic run_frame(input int rs_at, input int rmode, input bit drp, input int wt, input int stop_mel);
    int sent, guard;
    bit rs_done, s;
    step(1, 1, 0, rdy(rmode));
    sent = 1;
    rs_done = 0;
    while (sent < FB) begin
      if (!rs_done && rs_at > 0 && sent == rs_at) begin
        step(1, 1, 0, rdy(rmode));
        sent = 1;
        rs_done = 1;
      end else if ($urandom_range(0, 3) == 0) step(0, $urandom_range(0, 1) == 1, 0, rdy(rmode));
      else begin
        step(1, 0, 0, rdy(rmode));
        sent++;
      end
    end
    if (!in_frame) return;
    repeat (wt) step(0, 0, 0, rdy(rmode));
    step(0, 0, 1, rdy(rmode));
    guard = 0;
    while (in_frame && guard < 1000) begin
      if (stop_mel >= 0 && t_log >= 0 && cyc == t_log + stop_mel) return;
      s = drp && $urandom_range(0, 3) == 0;
      step(s, s, 0, rdy(rmode));
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      errors++;
      $error("FAIL frame_timeout cyc %0d got busy exp idle", cyc);
    end
  endtask

  initial begin
    #3_000_000;
    $error("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(0);
    run_frame(-1, 0, 0, 4, -1);
    run_frame(-1, 1, 0, $urandom_range(0, 6), -1);
    run_frame(60, 2, 0, $urandom_range(0, 6), -1);
    run_frame(FB - 1, 2, 0, $urandom_range(0, 6), -1);
    run_frame(-1, 2, 1, $urandom_range(0, 6), -1);
    run_frame(-1, 0, 0, 3, 17);
    do_reset(0);
    run_frame(-1, 0, 0, 2, -1);
    do_reset(1);
    repeat (6) run_frame(-1, 0, 0, 3, -1);
    repeat (9) run_frame(-1, 2, 1, $urandom_range(0, 6), -1);
    repeat (3) step(0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
